// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the oversampling timing constants.
package uart_pkg;

  localparam int unsigned Oversample  = 16;
  localparam int unsigned SamplePoint = 7;
  localparam int unsigned TickW       = $clog2(Oversample);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with combinational head output; power-of-two depth so pointers wrap naturally.
module uart_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       valid,
  output logic       drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    mem_q [DEPTH];
  logic          full, do_push, do_pop;

  assign valid   = (count_q != '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, 8N1 or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO
// with sticky frame/overrun/parity error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       clr_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned Div  = CLK_FREQ / (BAUD * Oversample);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

  uart_state_e      state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_s, rx_prev_q, fall;
  logic [DivW-1:0]  div_cnt_q;
  logic [TickW-1:0] tick_idx_q;
  logic             tick, sample;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             phase_rst, shift_en, push, frame_set, drop;
  logic             frame_err_q, overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[1];
  // rx_prev tracks the line in every state, so a line still low after STOP cannot re-trigger.
  assign fall = rx_prev_q && !rx_s;

  assign tick   = (div_cnt_q == DivW'(Div - 1));
  assign sample = tick && (tick_idx_q == TickW'(SamplePoint));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q  <= '0;
      tick_idx_q <= '0;
    end else if (phase_rst) begin
      div_cnt_q  <= '0;
      tick_idx_q <= '0;
    end else if (tick) begin
      div_cnt_q  <= '0;
      tick_idx_q <= tick_idx_q + 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit periods are 16 ticks apart, so every state samples when tick_idx wraps back to 7.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fall) state_d = StStart;
      StStart:  if (sample) state_d = rx_s ? StIdle : StData;
      StData: begin
        if (sample && bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: if (sample) state_d = StStop;
      StStop:   if (sample) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    phase_rst = (state_q == StIdle) && fall;
    shift_en  = (state_q == StData) && sample;
    push      = (state_q == StStop) && sample && rx_s;
    frame_set = (state_q == StStop) && sample && !rx_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      if (phase_rst) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[7:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (clr_err) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_set) frame_err_q <= 1'b1;
      if (drop)      overrun_q   <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
  logic parity_set, parity_err_q;

  assign parity_set = (state_q == StParity) && sample && (rx_s != ^shift_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else if (clr_err) begin
      parity_err_q <= 1'b0;
    end else if (parity_set) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  uart_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (shift_q),
    .pop   (rd_en),
    .rdata (rd_data),
    .valid (rd_valid),
    .drop  (drop)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (432 clocks per bit).
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BitClks = 432;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  // 2 sync flops + edge detect, then 27-clock ticks up to tick 7 of the stop bit period.
  localparam int StopEdge = 3 + 27 * (16 * (FrameBits - 1) + 8);

  logic       clk = 1'b0;
  logic       reset, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, overrun, parity_err;
  int         passed = 0;
  int         total  = 0;
  logic       vb, va;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clr_err    (clr_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drives one frame; pop_at pulses rd_en for the edge with that index; v_* bracket StopEdge.
  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic bad_par,
                           input int pop_at, output logic v_before, output logic v_after);
    logic [10:0] bits;
    logic        par;
    par = (^d) ^ bad_par;
`ifdef UART_RX_PARITY_EN
    bits = {stop_b, par, d, 1'b0};
`else
    bits = {par, stop_b, d, 1'b0};
`endif
    v_before = 1'b0;
    v_after  = 1'b0;
    for (int n = 1; n <= FrameBits * BitClks; n++) begin
      rx    = bits[(n - 1) / BitClks];
      rd_en = (n == pop_at);
      @(negedge clk);
      if (n == StopEdge - 1) v_before = rd_valid;
      if (n == StopEdge)     v_after  = rd_valid;
    end
    rd_en = 1'b0;
    rx    = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {7'd0, rd_valid}, 8'd0);
    check("rst_data", rd_data, 8'h00);
    check("rst_frame_err", {7'd0, frame_err}, 8'd0);
    check("rst_overrun", {7'd0, overrun}, 8'd0);
    check("rst_parity_err", {7'd0, parity_err}, 8'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte and its exact arrival cycle.
    send_byte(8'hA5, 1'b1, 1'b0, 0, vb, va);
    check("a5_valid_before_stop", {7'd0, vb}, 8'd0);
    check("a5_valid_after_stop", {7'd0, va}, 8'd1);
    check("a5_data", rd_data, 8'hA5);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("a5_popped", {7'd0, rd_valid}, 8'd0);

    // Start-bit glitch.
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_state", {5'd0, dut.state_q}, {5'd0, StIdle});
    check("glitch_valid", {7'd0, rd_valid}, 8'd0);
    check("glitch_frame_err", {7'd0, frame_err}, 8'd0);
    check("glitch_overrun", {7'd0, overrun}, 8'd0);

    // Framing error.
    send_byte(8'h3C, 1'b0, 1'b0, 0, vb, va);
    check("frame_err_set", {7'd0, frame_err}, 8'd1);
    check("frame_valid", {7'd0, rd_valid}, 8'd0);
    clear_errors();
    check("frame_err_clr", {7'd0, frame_err}, 8'd0);

    // Overrun: fifth byte dropped.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0, 0, vb, va);
    check("ovr_set", {7'd0, overrun}, 8'd1);
    for (int i = 1; i <= 4; i++) pop_expect("ovr_pop", 8'(i));
    check("ovr_empty", {7'd0, rd_valid}, 8'd0);
    clear_errors();
    check("ovr_clr", {7'd0, overrun}, 8'd0);

    // Push and pop on the same edge while full: no overrun, pointers wrap.
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 1'b0, 0, vb, va);
    send_byte(8'h15, 1'b1, 1'b0, StopEdge, vb, va);
    check("simul_overrun", {7'd0, overrun}, 8'd0);
    for (int i = 2; i <= 5; i++) pop_expect("simul_pop", 8'h10 + 8'(i));
    check("simul_empty", {7'd0, rd_valid}, 8'd0);

    // Reset during data bit 3 of 0xFF.
    rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BitClks + 200) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_state", {5'd0, dut.state_q}, {5'd0, StIdle});
    reset = 1'b0;
    repeat (6 * BitClks) @(negedge clk);
    check("midrst_no_byte", {7'd0, rd_valid}, 8'd0);
    send_byte(8'h5A, 1'b1, 1'b0, 0, vb, va);
    check("midrst_valid", {7'd0, rd_valid}, 8'd1);
    pop_expect("midrst_data", 8'h5A);
    check("midrst_only_one", {7'd0, rd_valid}, 8'd0);
    check("midrst_frame_err", {7'd0, frame_err}, 8'd0);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h07, 1'b1, 1'b1, 0, vb, va);
    check("par_err_set", {7'd0, parity_err}, 8'd1);
    pop_expect("par_data", 8'h07);
`else
    check("par_err_tied", {7'd0, parity_err}, 8'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
